// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit start validation,
// centre sampling of each data bit, one-cycle valid and framing-error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 500
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      r_State;
    logic        r_Rx_Meta;
    logic        r_Rx_Sync;
    logic [15:0] r_Clk_Count;
    logic [2:0]  r_Bit_Index;
    logic [7:0]  r_Shift;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Rx_Meta <= 1'b1;
            r_Rx_Sync <= 1'b1;
        end else begin
            r_Rx_Meta <= i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State     <= IDLE;
            r_Clk_Count <= 16'd0;
            r_Bit_Index <= 3'd0;
            r_Shift     <= 8'h00;
            o_Rx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Rx_Active <= 1'b0;
            o_Rx_Byte   <= 8'h00;
        end else begin
            o_Rx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;

            case (r_State)
                IDLE: begin
                    r_Clk_Count <= 16'd0;
                    r_Bit_Index <= 3'd0;
                    if (!r_Rx_Sync) begin
                        r_State     <= START;
                        o_Rx_Active <= 1'b1;
                    end
                end

                // A line that is high again at mid-start-bit was only a glitch.
                START: begin
                    if (r_Clk_Count == HALF_BIT) begin
                        r_Clk_Count <= 16'd0;
                        if (!r_Rx_Sync) begin
                            r_State <= DATA;
                        end else begin
                            r_State     <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 16'd1;
                    end
                end

                DATA: begin
                    if (r_Clk_Count == LAST_CLK) begin
                        r_Clk_Count          <= 16'd0;
                        r_Shift[r_Bit_Index] <= r_Rx_Sync;
                        if (r_Bit_Index == 3'd7) begin
                            r_Bit_Index <= 3'd0;
                            r_State     <= STOP;
                        end else begin
                            r_Bit_Index <= r_Bit_Index + 3'd1;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 16'd1;
                    end
                end

                STOP: begin
                    if (r_Clk_Count == LAST_CLK) begin
                        r_Clk_Count <= 16'd0;
                        o_Rx_Active <= 1'b0;
                        if (r_Rx_Sync) begin
                            o_Rx_Byte <= r_Shift;
                            o_Rx_DV   <= 1'b1;
                            r_State   <= IDLE;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            r_State     <= WAIT_HIGH;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 16'd1;
                    end
                end

                // Swallow a break so it reports only one framing error.
                WAIT_HIGH: begin
                    r_Clk_Count <= 16'd0;
                    r_Bit_Index <= 3'd0;
                    if (r_Rx_Sync) begin
                        r_State <= IDLE;
                    end
                end

                default: begin
                    r_State     <= IDLE;
                    r_Clk_Count <= 16'd0;
                    r_Bit_Index <= 3'd0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, glitch, framing error/break,
// async reset mid-frame, baud mismatch, and a 500-clock loopback stream.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rxSerial;
    logic       rxDv;
    logic [7:0] rxByte;
    logic       rxActive;
    logic       frameErr;

    logic       txLine;
    logic       rx2Dv;
    logic [7:0] rx2Byte;
    logic       rx2Active;
    logic       rx2FrameErr;

    int assertCount = 0;
    int failCount   = 0;

    int cycleCnt   = 0;
    int edge0      = 0;
    int dvCount    = 0;
    int dvRel      = -1;
    int errCount   = 0;
    int errRel     = -1;
    int bothCount  = 0;
    int activeRise = -1;
    int activeFall = -1;
    logic prevActive = 1'b0;

    int rx2DvCount  = 0;
    int rx2ErrCount = 0;
    logic [7:0] rx2Bytes[$];

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rxSerial),
        .o_Rx_DV     (rxDv),
        .o_Rx_Byte   (rxByte),
        .o_Rx_Active (rxActive),
        .o_Frame_Err (frameErr)
    );

    uart_rx #(.CLKS_PER_BIT(500)) dutLoop (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (txLine),
        .o_Rx_DV     (rx2Dv),
        .o_Rx_Byte   (rx2Byte),
        .o_Rx_Active (rx2Active),
        .o_Frame_Err (rx2FrameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter; edge n of a frame is reached when cycleCnt == edge0 + n.
    always @(posedge clk) cycleCnt++;

    // Output monitor sampled on the falling edge, relative to the frame's edge 0.
    always @(negedge clk) begin
        if (rxDv) begin
            dvCount++;
            dvRel = cycleCnt - edge0;
        end
        if (frameErr) begin
            errCount++;
            errRel = cycleCnt - edge0;
        end
        if (rxDv && frameErr) bothCount++;
        if (rxActive && !prevActive && activeRise < 0) activeRise = cycleCnt - edge0;
        if (!rxActive && prevActive) activeFall = cycleCnt - edge0;
        prevActive = rxActive;
        if (rx2Dv) begin
            rx2DvCount++;
            rx2Bytes.push_back(rx2Byte);
        end
        if (rx2FrameErr) rx2ErrCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        dvCount    = 0;
        dvRel      = -1;
        errCount   = 0;
        errRel     = -1;
        activeRise = -1;
        activeFall = -1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame; bit period given in hundredths of a clock so
    // fast/slow baud rates accumulate fractional timing correctly.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int centi);
        logic [9:0] frame;
        int elapsed;
        int boundary;
        frame   = {stopBit, data, 1'b0};
        elapsed = 0;
        edge0   = cycleCnt + 1;
        for (int k = 0; k < 10; k++) begin
            rxSerial = frame[k];
            boundary = ((k + 1) * centi + 50) / 100;
            while (elapsed < boundary) begin
                @(posedge clk);
                #1;
                elapsed++;
            end
        end
    endtask

    // Ideal transmitter: full stop bit plus one cleanup cycle between frames.
    task automatic txSendByte(input logic [7:0] data, input int idx);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            txLine = frame[k];
            waitCycles(500);
        end
        waitCycles(1);
        checkOutput($sformatf("loop_dv_before_done%0d", idx), 32'(rx2DvCount), 32'(idx + 1));
    endtask

    task automatic receiveAndCheck(input string tag, input logic [7:0] data, input int centi);
        clearMonitor();
        applyStimulus(data, 1'b1, centi);
        waitCycles(4);
        checkOutput({tag, "_dv"}, 32'(dvCount), 32'd1);
        checkOutput({tag, "_byte"}, 32'(rxByte), 32'(data));
        checkOutput({tag, "_ferr"}, 32'(errCount), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rxSerial = 1'b1;
        txLine   = 1'b1;
        waitCycles(3);
        checkOutput("reset_dv", 32'(rxDv), 32'd0);
        checkOutput("reset_byte", 32'(rxByte), 32'h00);
        checkOutput("reset_active", 32'(rxActive), 32'd0);
        checkOutput("reset_ferr", 32'(frameErr), 32'd0);
        rst = 1'b0;
        waitCycles(5);

        // Single byte: strobe and active window pinned to exact edges.
        clearMonitor();
        applyStimulus(8'hA5, 1'b1, 1600);
        waitCycles(4);
        checkOutput("a5_dv_count", 32'(dvCount), 32'd1);
        checkOutput("a5_dv_edge", 32'(dvRel), 32'd154);
        checkOutput("a5_byte", 32'(rxByte), 32'hA5);
        checkOutput("a5_ferr", 32'(errCount), 32'd0);
        checkOutput("a5_active_rise", 32'(activeRise), 32'd2);
        checkOutput("a5_active_fall", 32'(activeFall), 32'd154);

        // Glitch of 5 low cycles, rejected at the mid-start check (edge 10).
        clearMonitor();
        edge0 = cycleCnt + 1;
        rxSerial = 1'b0;
        waitCycles(5);
        rxSerial = 1'b1;
        waitCycles(30);
        checkOutput("glitch_dv", 32'(dvCount), 32'd0);
        checkOutput("glitch_ferr", 32'(errCount), 32'd0);
        checkOutput("glitch_active_fall", 32'(activeFall), 32'd10);
        checkOutput("glitch_byte_held", 32'(rxByte), 32'hA5);
        receiveAndCheck("after_glitch_3c", 8'h3C, 1600);

        // Framing error followed by a 40-bit break.
        receiveAndCheck("pre_ferr_11", 8'h11, 1600);
        clearMonitor();
        applyStimulus(8'h7E, 1'b0, 1600);
        waitCycles(40 * 16 - 16);
        checkOutput("ferr_count", 32'(errCount), 32'd1);
        checkOutput("ferr_edge", 32'(errRel), 32'd154);
        checkOutput("ferr_no_dv", 32'(dvCount), 32'd0);
        checkOutput("ferr_byte_held", 32'(rxByte), 32'h11);
        rxSerial = 1'b1;
        waitCycles(20);
        checkOutput("break_end_ferr", 32'(errCount), 32'd1);
        checkOutput("break_end_dv", 32'(dvCount), 32'd0);
        receiveAndCheck("after_break_81", 8'h81, 1600);

        // Async reset during data bit 4 of 0xC3, held until the frame is gone.
        clearMonitor();
        fork
            applyStimulus(8'hC3, 1'b1, 1600);
            begin
                repeat (85) @(posedge clk);
                #3;
                checkOutput("pre_reset_active", 32'(rxActive), 32'd1);
                rst = 1'b1;
                #1;
                checkOutput("midreset_active", 32'(rxActive), 32'd0);
                checkOutput("midreset_byte", 32'(rxByte), 32'h00);
                checkOutput("midreset_dv", 32'(rxDv), 32'd0);
            end
        join
        waitCycles(10);
        rst = 1'b0;
        waitCycles(10);
        checkOutput("abandoned_dv", 32'(dvCount), 32'd0);
        checkOutput("abandoned_ferr", 32'(errCount), 32'd0);
        receiveAndCheck("after_reset_5a", 8'h5A, 1600);

        // Baud mismatch: 2% fast (15.68 clk/bit) and 2% slow (16.32 clk/bit).
        receiveAndCheck("fast_96", 8'h96, 1568);
        receiveAndCheck("fast_69", 8'h69, 1568);
        receiveAndCheck("slow_96", 8'h96, 1632);
        receiveAndCheck("slow_69", 8'h69, 1632);

        // Back-to-back stream into the 500-clock receiver.
        rx2DvCount  = 0;
        rx2ErrCount = 0;
        rx2Bytes.delete();
        txSendByte(8'h00, 0);
        txSendByte(8'hFF, 1);
        txSendByte(8'h55, 2);
        waitCycles(10);
        checkOutput("loop_dv_count", 32'(rx2DvCount), 32'd3);
        checkOutput("loop_ferr", 32'(rx2ErrCount), 32'd0);
        checkOutput("loop_queue_size", 32'(rx2Bytes.size()), 32'd3);
        if (rx2Bytes.size() == 3) begin
            checkOutput("loop_byte0", 32'(rx2Bytes[0]), 32'h00);
            checkOutput("loop_byte1", 32'(rx2Bytes[1]), 32'hFF);
            checkOutput("loop_byte2", 32'(rx2Bytes[2]), 32'h55);
        end

        checkOutput("dv_ferr_overlap", 32'(bothCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for 8 data bits, 1 start bit, 1 stop bit, no parity (8N1), LSB first. It is the receive-side counterpart of the existing UART transmitter and uses the same CLKS_PER_BIT convention, so a transmitter and receiver built with equal parameters interoperate directly. The block synchronises the asynchronous serial pin, validates the start bit at mid-bit, and samples each bit at its centre. It presents each received byte with a one-cycle valid strobe and flags framing errors.

## Interface
- CLKS_PER_BIT, default 500: clock cycles per bit, computed as f(i_Clock) / baud. Legal range is 4..65535. Define H = (CLKS_PER_BIT-1)/2, using integer division.
- i_Clock, input, 1: the single clock. All logic is on the rising edge.
- i_Reset, input, 1: asynchronous, active-high reset.
- i_Rx_Serial, input, 1: asynchronous serial line. The line idles high.
- o_Rx_DV, output, 1: one-cycle pulse meaning o_Rx_Byte holds a new, good byte.
- o_Rx_Byte, output, 8: last good byte. It is held until the next good byte.
- o_Rx_Active, output, 1: high while a frame is being received.
- o_Frame_Err, output, 1: one-cycle pulse meaning the stop bit was sampled low.

## Operation
**Input synchroniser**
- Two-flop synchroniser on i_Rx_Serial. Both flops reset to 1.
- All decisions use only the second flop, called rx_s.

**Bit counter and bit index**
- The bit counter is 16 bits wide, independent of CLKS_PER_BIT.
- The bit index is 3 bits wide. Bit i is written to internal shift-register bit i, LSB first.

**States**
- IDLE
  - Counter and index are 0.
  - If rx_s = 0, go to START with counter = 0 and o_Rx_Active = 1.
- START
  - Count up to H.
  - When counter = H and rx_s = 0: go to DATA, counter = 0.
  - When counter = H and rx_s = 1 (glitch): go to IDLE, o_Rx_Active = 0. No strobe is produced.
- DATA
  - Count up to CLKS_PER_BIT-1.
  - On that cycle: store rx_s into bit[index] and set counter = 0.
  - If index < 7, increment index. Otherwise set index = 0 and go to STOP.
- STOP
  - Count up to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s = 1: o_Rx_Byte <= shift register, o_Rx_DV = 1 for one cycle, o_Rx_Active = 0, go to IDLE.
  - rx_s = 0: o_Frame_Err = 1 for one cycle, o_Rx_Byte unchanged, o_Rx_Active = 0, go to WAIT_HIGH.
- WAIT_HIGH
  - Stay until rx_s = 1, then go to IDLE.
  - A break (line held low) therefore yields exactly one o_Frame_Err and no further frames.
- Any undefined state encoding goes to IDLE.

**Reset**
- Reset values: o_Rx_DV = 0, o_Frame_Err = 0, o_Rx_Active = 0, o_Rx_Byte = 0x00.
- Also reset: state IDLE, counter 0, index 0, shift register 0.
- Reset mid-frame abandons the frame silently: no strobe on either output.
- After reset release, the next falling edge on the line starts a new frame.

**Output behaviour**
- o_Rx_DV and o_Frame_Err are never high in the same cycle.
- Each of o_Rx_DV and o_Frame_Err is high for at most one cycle per frame.

## Timing
**Reference edge**
- Edge 0 is the first rising edge at which the first synchroniser flop captures i_Rx_Serial = 0.
- rx_s is low after edge 1. IDLE detects it at edge 2, entering START with counter = 0.

**Sampling edges**
- Start-bit check at edge 3+H.
- Data bit i (i = 0..7) sampled at edge 3+H+(i+1)·CLKS_PER_BIT.
- Stop bit sampled at edge 3+H+9·CLKS_PER_BIT.

**Outputs**
- o_Rx_DV or o_Frame_Err is high during the cycle immediately after edge 3+H+9·CLKS_PER_BIT.
- o_Rx_Byte updates on that same edge.
- o_Rx_Active rises after edge 2 and falls on that same edge.

**Back-to-back frames**
- The receiver is in IDLE by mid-stop-bit, so it accepts a new start bit within half a bit after the stop-bit sample.
- The transmitter's frame spacing (full stop bit plus one cleanup cycle) is always accepted.

**Jitter tolerance**
- Sampling lands within ±1 clock of bit centre, plus the two-cycle synchroniser delay.
- Tolerates a baud mismatch of at least ±2% for CLKS_PER_BIT ≥ 16.

**Example**
- With CLKS_PER_BIT = 16 (H = 7), o_Rx_DV is high in the cycle after edge 154.

## Test plan
- **Single byte (CLKS_PER_BIT = 16):** drive 0xA5 as ideal 8N1 with edge-aligned bits. Expect o_Rx_DV high for exactly one cycle after edge 154, o_Rx_Byte = 0xA5, o_Frame_Err never high, and o_Rx_Active high from after edge 2 through edge 154.
- **Glitch rejection:** drive a low pulse of 5 cycles (< H) on the idle line. Expect no o_Rx_DV and no o_Frame_Err, o_Rx_Active to fall after edge 10, and a following valid 0x3C to be received correctly.
- **Framing error:** receive 0x11 as a good frame, then send 0x7E with the stop bit low and hold the line low for 40 bit times. Expect exactly one o_Frame_Err pulse, o_Rx_Byte to stay 0x11, and no further strobes until the line returns high; a subsequent 0x81 is received correctly.
- **Loopback with the transmitter (both at CLKS_PER_BIT = 500):** send 0x00, 0xFF, 0x55 back-to-back. Expect three o_Rx_DV pulses with bytes in order, no o_Frame_Err, and each o_Rx_DV to precede the matching o_Tx_Done.
- **Reset mid-frame:** assert i_Reset asynchronously (between clock edges) during data bit 4 of 0xC3. Expect all outputs to go to reset values immediately and no strobe for the abandoned frame; after release, 0x5A is received correctly.
- **Baud mismatch:** drive the stimulus at 2% fast and then 2% slow relative to CLKS_PER_BIT = 16 for bytes 0x96 and 0x69. Expect all bytes received correctly with no framing error.
